// File: rtl/alu_mdu.sv
// alu_mdu: single-issue ALU with iterative multiply/divide unit.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  request handshake (op, a, b captured on accept)
//   op[4:0]             operation select (op[4]=0: single-cycle ALU op)
//   a, b                XLEN-bit operands
//   out_valid,out_ready result handshake; result held while out_ready=0
//   result              registered XLEN-bit result
//   busy                high while a multiply or divide is iterating
//
// Build option: define ALU_MDU_DIV_EN to include div/divu/rem/remu. Without
// it those op codes complete in one cycle with result 0 and no divider
// datapath is built.

`timescale 1ns/1ps

module alu_mdu #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  // hi/lo: partial product (mul) or partial remainder / dividend-quotient (div)
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  // multiplicand magnitude (mul) or divisor magnitude (div)
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        sel_q, sel_d;
  // negate product (mul) or quotient (div) at the end
  logic              neg_q, neg_d;
`ifdef ALU_MDU_DIV_EN
  logic              rneg_q, rneg_d;
  logic              div0_q, div0_d;
`endif

  logic              accept;
  logic [XLEN-1:0]   alu_res;
  logic              mul_sa, mul_sb;
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_hi, mul_lo;
  logic [2*XLEN-1:0] mul_mag, mul_prod;
  logic [XLEN-1:0]   mul_res;
`ifdef ALU_MDU_DIV_EN
  logic              div_sgn;
  logic [XLEN:0]     div_sh;
  logic              div_ge;
  logic [XLEN-1:0]   div_hi, div_lo;
  logic [XLEN-1:0]   div_res;
`endif

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;

  // Single-cycle ALU result, computed straight from the request operands
  always_comb begin
    alu_res = '0;
    case (op)
      5'b00000: alu_res = a + b;
      5'b00001: alu_res = a - b;
      5'b00010: alu_res = a & b;
      5'b00011: alu_res = a | b;
      5'b00100: alu_res = a ^ b;
      5'b00101: alu_res = a >> b[SHW-1:0];
      5'b00110: alu_res = XLEN'($signed(a) >>> b[SHW-1:0]);
      5'b00111: alu_res = a << b[SHW-1:0];
      5'b01000: alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      5'b01001: alu_res = {{(XLEN-1){1'b0}}, (a < b)};
      5'b01110: alu_res = b;
      5'b01111: alu_res = a;
      default:  alu_res = '0;
    endcase
  end

  // Shift-add step on magnitudes: add multiplicand if lo LSB set, shift right
  always_comb begin
    mul_sa   = (op[1:0] == 2'b01) || (op[1:0] == 2'b10);
    mul_sb   = (op[1:0] == 2'b01);
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi   = mul_sum[XLEN:1];
    mul_lo   = {mul_sum[0], lo_q[XLEN-1:1]};
    mul_mag  = {mul_hi, mul_lo};
    mul_prod = neg_q ? -mul_mag : mul_mag;
    mul_res  = (sel_q == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
  end

`ifdef ALU_MDU_DIV_EN
  // Restoring step: shift next dividend bit into the remainder, subtract if it fits.
  // Divide-by-zero falls out naturally for the remainder (ends as |a|).
  always_comb begin
    div_sgn = ~op[0];
    div_sh  = {hi_q, lo_q[XLEN-1]};
    div_ge  = (div_sh >= {1'b0, opnd_q});
    div_hi  = div_ge ? (div_sh[XLEN-1:0] - opnd_q) : div_sh[XLEN-1:0];
    div_lo  = {lo_q[XLEN-2:0], div_ge};
    if (sel_q[1]) begin
      div_res = rneg_q ? -div_hi : div_hi;
    end else if (div0_q) begin
      div_res = '1;
    end else begin
      div_res = neg_q ? -div_lo : div_lo;
    end
  end
`endif

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    opnd_d      = opnd_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    neg_d       = neg_q;
`ifdef ALU_MDU_DIV_EN
    rneg_d      = rneg_q;
    div0_d      = div0_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if ((state_q == S_DONE) && out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
        if (accept) begin
          cnt_d = '0;
          sel_d = op[1:0];
          if (!op[4]) begin
            result_d    = alu_res;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else if (op[3:2] == 2'b00) begin
            hi_d        = '0;
            opnd_d      = (mul_sa && a[XLEN-1]) ? -a : a;
            lo_d        = (mul_sb && b[XLEN-1]) ? -b : b;
            neg_d       = (mul_sa && a[XLEN-1]) ^ (mul_sb && b[XLEN-1]);
            out_valid_d = 1'b0;
            state_d     = S_MUL;
`ifdef ALU_MDU_DIV_EN
          end else if (op[3:2] == 2'b01) begin
            hi_d        = '0;
            lo_d        = (div_sgn && a[XLEN-1]) ? -a : a;
            opnd_d      = (div_sgn && b[XLEN-1]) ? -b : b;
            neg_d       = div_sgn && (a[XLEN-1] ^ b[XLEN-1]);
            rneg_d      = div_sgn && a[XLEN-1];
            div0_d      = (b == '0);
            out_valid_d = 1'b0;
            state_d     = S_DIV;
`endif
          end else begin
            result_d    = '0;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end
      end
      S_MUL: begin
        hi_d  = mul_hi;
        lo_d  = mul_lo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN-1)) begin
          result_d    = mul_res;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DIV: begin
`ifdef ALU_MDU_DIV_EN
        hi_d  = div_hi;
        lo_d  = div_lo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN-1)) begin
          result_d    = div_res;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_MUL) || (state_d == S_DIV);
  end

  // State and output registers; reset discards any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
      cnt_q       <= '0;
      sel_q       <= '0;
      neg_q       <= 1'b0;
`ifdef ALU_MDU_DIV_EN
      rneg_q      <= 1'b0;
      div0_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      opnd_q      <= opnd_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      neg_q       <= neg_d;
`ifdef ALU_MDU_DIV_EN
      rneg_q      <= rneg_d;
      div0_q      <= div0_d;
`endif
    end
  end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; SHALL be 32 or 64.
REQ-002 Parameter SHW, default $clog2(XLEN), shift-amount width taken from b[SHW-1:0].
REQ-003 clk  input  1  clock; all state SHALL update on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 op  input  5  operation select (REQ-012).
REQ-008 a, b  input  XLEN each  operands.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  XLEN  registered result; busy output 1 high when state is MUL or DIV.

Function
REQ-012 op: 00000 add, 00001 sub, 00010 and, 00011 or, 00100 xor, 00101 srl, 00110 sra (arithmetic, signed), 00111 sll, 01000 slt, 01001 sltu, 01110 pass b, 01111 pass a, 10000 mul, 10001 mulh, 10010 mulhsu, 10011 mulhu, 10100 div, 10101 divu, 10110 rem, 10111 remu.
REQ-013 Unlisted op codes SHALL complete as ALU ops with result 0.
REQ-014 slt/sltu SHALL produce full-width zero-extended 0 or 1; no output bit SHALL hold a stale value (no latches).
REQ-015 add/sub/mul low SHALL wrap modulo 2^XLEN; mulh* SHALL return upper XLEN bits of the 2*XLEN product with operand signedness per RISC-V M.
REQ-016 FSM states IDLE, MUL, DIV, DONE; handshake occurs when in_valid && in_ready.
REQ-017 in_ready SHALL be 1 in IDLE, or in DONE when out_ready is 1; 0 in MUL and DIV.
REQ-018 ALU ops (op[4]=0): accepted in cycle N, result and out_valid SHALL be presented in cycle N+1 (state DONE).
REQ-019 MUL ops: iterative shift-add, one bit per cycle; out_valid SHALL assert exactly XLEN+1 cycles after acceptance.
REQ-020 DIV ops: iterative restoring division on magnitudes, sign-corrected at end; out_valid SHALL assert exactly XLEN+1 cycles after acceptance.
REQ-021 Divide by zero: div/divu SHALL return all-ones; rem/remu SHALL return a; latency unchanged.
REQ-022 Signed overflow (a = most-negative, b = -1): div SHALL return a; rem SHALL return 0.
REQ-023 In DONE, result and out_valid SHALL hold stable until out_ready=1; then state SHALL go IDLE, or directly to next op if a new request is accepted that cycle (back-to-back).
REQ-024 Operands SHALL be captured at acceptance; changes on a/b/op afterwards SHALL not affect the result.
REQ-025 in_valid during MUL/DIV SHALL be ignored (not accepted, not queued).

Reset
REQ-026 On rst_n low, asynchronously: state IDLE, out_valid 0, result 0, busy 0, in_ready 1 after release; any in-flight MUL/DIV SHALL be discarded.
REQ-027 First request SHALL be accepted on the first rising edge with rst_n high.

Configuration
REQ-028 Macro ALU_MDU_DIV_EN: when defined, div/divu/rem/remu and DIV state are implemented per REQ-020..022.
REQ-029 When ALU_MDU_DIV_EN is undefined, op 10100..10111 SHALL complete as ALU ops (1-cycle latency) with result 0, and no divider logic SHALL be synthesised.

Verification
REQ-030 add a=0x7FFFFFFF b=1 -> result 0x80000000, out_valid one cycle after accept; sra a=0x80000000 b=4 -> 0xF8000000.
REQ-031 sltu a=1 b=0xFFFFFFFF after prior op result 0xFFFFFFFF -> result 0x00000001 exactly (no stale upper bits).
REQ-032 mulh a=0xFFFFFFFF b=0xFFFFFFFF -> 0x00000000; mulhu same operands -> 0xFFFFFFFE; out_valid 33 cycles after accept.
REQ-033 div a=0x80000000 b=0xFFFFFFFF -> 0x80000000; rem -> 0; divu a=5 b=0 -> 0xFFFFFFFF; remu a=5 b=0 -> 5.
REQ-034 out_ready held 0 for 5 cycles in DONE -> result stable, in_ready 0; then out_ready=1 with in_valid=1 -> new op accepted same cycle.
REQ-035 rst_n pulsed low 10 cycles into a div -> out_valid 0 immediately, state IDLE, no result ever emitted for that op.
